rand_roll_n: RTL and testbench
==============================

Name: rand_roll_n

Overview:
- Parametrised multi-digit random-number roller that replaces the single-digit one-shot generator.
- A one-cycle run pulse from btn_in starts a timed "rolling" animation, with digits refreshed every tick; it then settles on a final value and pulses done.
- An optional second press stops the roll early.
- Drives NUM_DIGITS BCD nibbles into per-digit seg7dec instances on the board top level.

Parameters:
- NUM_DIGITS, 2: number of 4-bit output digits; 1..4; 4*NUM_DIGITS <= LFSR_W.
- LFSR_W, 16: LFSR width; one of 8, 16, 24, 32.
- SEED, 16'hACE1: LFSR reset value; must be nonzero.
- TICK_DIV, 50000: clocks per animation tick (1 ms at 50 MHz); >= 2.
- ROLL_TICKS, 300: ticks per roll before auto-settle; >= 1.
- MAX_DIGIT, 9: largest legal digit value; 1..15.
- STOP_EN, 1: 1 = run_in during ROLL stops early; 0 = ignored.

Ports:
- CLK, input, 1: system clock.
- RST, input, 1: asynchronous active-high reset.
- run_in, input, 1: single-cycle start/stop pulse, already debounced.
- num, output, 4*NUM_DIGITS: digits; digit i = num[4i+3:4i], digit 0 least significant.
- rolling, output, 1: high while in ROLL.
- done, output, 1: one-cycle pulse when the final value appears on num.

Behaviour:
- Reset (async, RST=1): state IDLE; lfsr=SEED; tick counter=0; roll counter=0; num=0; rolling=0; done=0.
- LFSR:
  - Galois, right-shift; advances every clock in all states, so press timing adds entropy.
  - Update: lsb=l[0]; l=l>>1; if lsb, l ^= TAPS(LFSR_W).
  - If l is ever all-zero, reload SEED on the next clock.
- Digit map, per digit: raw = lfsr[4i+3:4i]; if raw > MAX_DIGIT, digit = raw - (MAX_DIGIT+1), repeated until <= MAX_DIGIT; else digit = raw. The bias is accepted.
- States: IDLE, ROLL.
- IDLE:
  - num holds its last value.
  - run_in=1 at cycle t: state=ROLL and rolling=1 at t+1; tick and roll counters cleared.
- ROLL:
  - Tick counter counts 0..TICK_DIV-1 and wraps; a tick occurs on the wrap.
  - Each tick: num <= map(lfsr); roll counter++.
  - The k-th tick's value is visible at cycle t+1+k*TICK_DIV.
  - On tick number ROLL_TICKS, in the same register update: num gets the final map, done=1, rolling=0, state=IDLE.
  - done is therefore high exactly at cycle t+1+ROLL_TICKS*TICK_DIV.
- Early stop (STOP_EN=1): run_in=1 in ROLL at cycle s → at s+1: num=map(lfsr at s), done=1, rolling=0, IDLE.
- Early stop (STOP_EN=0): run_in in ROLL has no effect.
- Simultaneous run_in and a tick in ROLL: one settle only, using map(lfsr) of that cycle; done is a single pulse.
- run_in in the same cycle done is high: state is already IDLE on the next edge, so that press is lost. A press one cycle later starts a new roll.
- done never lasts more than one cycle; rolling and done are never both 1.
- Counter widths: $clog2(TICK_DIV) and $clog2(ROLL_TICKS+1); no overflow by construction.
- Reset mid-roll: immediate return to reset values; no done pulse.

Decomposition:
- Package rand_pkg holds:
  - state enum {IDLE, ROLL};
  - function lfsr_taps(width): 8→8'hB8, 16→16'hB400, 24→24'hE10000, 32→32'hA3000000;
  - function digit_map(raw, max).
- One sub-module, lfsr_galois (params W, SEED, TAPS; ports CLK, RST, q): free-running with zero-state recovery.
- Counters, FSM and mapping live in rand_roll_n.

Test Plan:
- Reset, defaults NUM_DIGITS=2 → num=8'h00, rolling=0, done=0; assert RST mid-roll → same values within the cycle, no done.
- lfsr_galois W=16, SEED=16'hACE1 → q=16'hE270 after 1 clock, 16'h7138 after 2; force zero state → SEED on next clock.
- digit_map, MAX_DIGIT=9 → raw 4'h9 gives 9; 4'hC gives 2; 4'hF gives 5; MAX_DIGIT=5 with raw 4'hF gives 3.
- TICK_DIV=4, ROLL_TICKS=3, run_in at t → rolling=1 from t+1; num changes at t+5 and t+9; done=1 only at t+13 with rolling=0; every digit <= 9 throughout.
- STOP_EN=1, same params, run_in at t and again at t+6 → done at t+7, num=map(lfsr@t+6); with STOP_EN=0, second press ignored and done at t+13.
- Press coincident with the final tick → single done pulse; press at done+1 → new roll starts, rolling=1 next cycle.

Source files
------------

// File: rtl/rand_pkg.sv
// Shared types and helpers for the multi-digit random roller.
package rand_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    ROLL = 1'b1
  } state_e;

  // Galois tap masks for the supported LFSR widths.
  function automatic logic [31:0] lfsr_taps(input int width);
    logic [31:0] taps;
    case (width)
      8:       taps = 32'h0000_00B8;
      16:      taps = 32'h0000_B400;
      24:      taps = 32'h00E1_0000;
      32:      taps = 32'hA300_0000;
      default: taps = 32'h0000_B400;
    endcase
    return taps;
  endfunction

  // Fold an out-of-range nibble back into 0..max_v by repeated subtraction.
  function automatic logic [3:0] digit_map(input logic [3:0] raw, input logic [3:0] max_v);
    logic [4:0] v;
    v = {1'b0, raw};
    for (int i = 0; i < 15; i++) begin
      if (v > {1'b0, max_v}) begin
        v = v - ({1'b0, max_v} + 5'd1);
      end else begin
        v = v;
      end
    end
    return v[3:0];
  endfunction

endpackage

// File: rtl/rand_roll_n_if.sv
// Run/result bus between the roller and whatever drives and displays it.
interface rand_roll_n_if #(
  parameter int NUM_DIGITS = 2
) ();
  logic                    run_in;
  logic [4*NUM_DIGITS-1:0] num;
  logic                    rolling;
  logic                    done;

  modport master (output run_in, input num, input rolling, input done);
  modport slave  (input run_in, output num, output rolling, output done);
endinterface

// File: rtl/rand_roll_n_lfsr_galois.sv
// Free-running right-shift Galois LFSR that reloads its seed if it ever sees zero.
module lfsr_galois #(
  parameter int           W    = 16,
  parameter logic [W-1:0] SEED = W'(16'hACE1),
  parameter logic [W-1:0] TAPS = W'(16'hB400)
) (
  input  logic         CLK,
  input  logic         RST,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  // Next state: one Galois step, or the seed when stuck at zero.
  always_comb begin
    q_d = q_q;
    if (q_q == {W{1'b0}}) begin
      q_d = SEED;
    end else if (q_q[0]) begin
      q_d = (q_q >> 1) ^ TAPS;
    end else begin
      q_d = q_q >> 1;
    end
  end

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      q_q <= SEED;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/rand_roll_n.sv
// Multi-digit BCD roller: a run pulse animates the digits every tick, then
// settles after ROLL_TICKS ticks (or on a second press) and pulses done.
module rand_roll_n
  import rand_pkg::*;
#(
  parameter int                NUM_DIGITS = 2,
  parameter int                LFSR_W     = 16,
  parameter logic [LFSR_W-1:0] SEED       = LFSR_W'(16'hACE1),
  parameter int                TICK_DIV   = 50000,
  parameter int                ROLL_TICKS = 300,
  parameter int                MAX_DIGIT  = 9,
  parameter int                STOP_EN    = 1
) (
  input logic          CLK,
  input logic          RST,
  rand_roll_n_if.slave bus
);

  localparam int                TW        = $clog2(TICK_DIV);
  localparam int                RW        = $clog2(ROLL_TICKS + 1);
  localparam logic [TW-1:0]     TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [RW-1:0]     ROLL_LAST = RW'(ROLL_TICKS - 1);
  localparam logic [3:0]        MAX_D     = 4'(MAX_DIGIT);
  localparam logic [LFSR_W-1:0] TAPS      = LFSR_W'(lfsr_taps(LFSR_W));

  state_e                  state_q;
  logic [TW-1:0]           tick_q;
  logic [RW-1:0]           roll_q;
  logic [4*NUM_DIGITS-1:0] num_q;
  logic [4*NUM_DIGITS-1:0] num_d;
  logic                    rolling_q;
  logic                    done_q;
  logic [LFSR_W-1:0]       lfsr_s;
  logic                    tick_s;
  logic                    stop_s;
  logic                    settle_s;
  logic                    unused_lfsr_s;

  lfsr_galois #(
    .W    (LFSR_W),
    .SEED (SEED),
    .TAPS (TAPS)
  ) u_lfsr (
    .CLK (CLK),
    .RST (RST),
    .q   (lfsr_s)
  );

  // Upper LFSR bits beyond the displayed digits only feed the sequence itself.
  assign unused_lfsr_s = ^lfsr_s;

  // Map the current LFSR nibbles onto legal digits.
  always_comb begin
    num_d = {(4*NUM_DIGITS){1'b0}};
    for (int i = 0; i < NUM_DIGITS; i++) begin
      num_d[4*i +: 4] = digit_map(lfsr_s[4*i +: 4], MAX_D);
    end
  end

  assign tick_s   = (state_q == ROLL) && (tick_q == TICK_LAST);
  assign stop_s   = (STOP_EN != 0) && (state_q == ROLL) && bus.run_in;
  assign settle_s = stop_s || (tick_s && (roll_q == ROLL_LAST));

  // Roll FSM with counters and registered outputs; a press during done is dropped.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= IDLE;
      tick_q    <= {TW{1'b0}};
      roll_q    <= {RW{1'b0}};
      num_q     <= {(4*NUM_DIGITS){1'b0}};
      rolling_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.run_in && !done_q) begin
            state_q   <= ROLL;
            rolling_q <= 1'b1;
            tick_q    <= {TW{1'b0}};
            roll_q    <= {RW{1'b0}};
          end
        end
        ROLL: begin
          tick_q <= tick_s ? {TW{1'b0}} : tick_q + TW'(1);
          if (settle_s) begin
            num_q     <= num_d;
            done_q    <= 1'b1;
            rolling_q <= 1'b0;
            state_q   <= IDLE;
          end else if (tick_s) begin
            num_q  <= num_d;
            roll_q <= roll_q + RW'(1);
          end
        end
        default: begin
          state_q   <= IDLE;
          rolling_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.num     = num_q;
  assign bus.rolling = rolling_q;
  assign bus.done    = done_q;

endmodule

// File: tb/tb_rand_roll_n.sv
// Scoreboard bench for rand_roll_n: two instances (stop enabled / disabled,
// max digit 9 / 5) share one random press stream against a cycle-level model.
module tb_rand_roll_n;
  import rand_pkg::*;

  localparam int TD = 4;
  localparam int RT = 3;

  typedef struct {
    int         cyc;
    logic [7:0] num;
  } exp_t;

  logic        clk   = 1'b0;
  logic        rst   = 1'b1;
  logic        run   = 1'b0;
  int          cyc   = 0;
  logic [15:0] mlfsr = 16'hACE1;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          rs[2] = '{-1, -1};
  int          re[2] = '{-1, -1};
  int          mx[2] = '{9, 5};
  bit          sten[2] = '{1'b1, 1'b0};
  exp_t        dq[2][$];
  exp_t        tq[2][$];
  exp_t        e_m;

  always #5 clk = ~clk;

  rand_roll_n_if #(.NUM_DIGITS(2)) if0 ();
  rand_roll_n_if #(.NUM_DIGITS(2)) if1 ();
  assign if0.run_in = run;
  assign if1.run_in = run;

  rand_roll_n #(.NUM_DIGITS(2), .LFSR_W(16), .SEED(16'hACE1), .TICK_DIV(TD),
                .ROLL_TICKS(RT), .MAX_DIGIT(9), .STOP_EN(1))
    u_dut0 (.CLK(clk), .RST(rst), .bus(if0));
  rand_roll_n #(.NUM_DIGITS(2), .LFSR_W(16), .SEED(16'hACE1), .TICK_DIV(TD),
                .ROLL_TICKS(RT), .MAX_DIGIT(5), .STOP_EN(0))
    u_dut1 (.CLK(clk), .RST(rst), .bus(if1));

  logic [15:0] lq;
  lfsr_galois #(.W(16), .SEED(16'hACE1), .TAPS(16'hB400))
    u_lfsr (.CLK(clk), .RST(rst), .q(lq));

  logic       done_w[2];
  logic       rol_w[2];
  logic [7:0] num_w[2];
  assign done_w[0] = if0.done;    assign done_w[1] = if1.done;
  assign rol_w[0]  = if0.rolling; assign rol_w[1]  = if1.rolling;
  assign num_w[0]  = if0.num;     assign num_w[1]  = if1.num;

  function automatic logic [15:0] mstep(logic [15:0] l);
    if (l == 16'h0000) return 16'hACE1;
    if (l[0]) return (l >> 1) ^ 16'hB400;
    return l >> 1;
  endfunction

  // Digit value is the nibble modulo (max+1).
  function automatic logic [7:0] mmap(logic [15:0] l, int m);
    int lo, hi;
    lo = int'(l) % 16;
    hi = (int'(l) / 16) % 16;
    return 8'((hi % (m + 1)) * 16 + (lo % (m + 1)));
  endfunction

  task automatic chk(string nm, int act, int expv);
    n_cmp++;
    if (act != expv) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, expv);
    end
  endtask

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    mlfsr <= rst ? 16'hACE1 : mstep(mlfsr);
  end

  // Monitor: pops expectations whenever the DUT shows a tick value or done.
  always @(negedge clk) begin
    if (!rst) begin
      for (int ch = 0; ch < 2; ch++) begin
        if (tq[ch].size() > 0 && tq[ch][0].cyc <= cyc) begin
          e_m = tq[ch].pop_front();
          chk($sformatf("tick_cyc%0d", ch), e_m.cyc, cyc);
          chk($sformatf("tick_num%0d", ch), num_w[ch], e_m.num);
        end
        if (done_w[ch]) begin
          if (dq[ch].size() == 0) begin
            chk($sformatf("unexpected_done%0d", ch), 1, 0);
          end else begin
            e_m = dq[ch].pop_front();
            chk($sformatf("done_cyc%0d", ch), cyc, e_m.cyc);
            chk($sformatf("done_num%0d", ch), num_w[ch], e_m.num);
          end
        end else if (dq[ch].size() > 0 && dq[ch][0].cyc <= cyc) begin
          e_m = dq[ch].pop_front();
          chk($sformatf("missing_done%0d", ch), 0, 1);
        end
        chk($sformatf("rolling%0d", ch), rol_w[ch], (rs[ch] < cyc && cyc < re[ch]) ? 1 : 0);
        chk($sformatf("excl%0d", ch), (rol_w[ch] && done_w[ch]) ? 1 : 0, 0);
        chk($sformatf("range%0d", ch),
            (int'(num_w[ch][3:0]) <= mx[ch] && int'(num_w[ch][7:4]) <= mx[ch]) ? 1 : 0, 1);
      end
    end
  end

  // Model of a press sampled at the end of the current cycle.
  task automatic press_model(int ch);
    exp_t        e;
    logic [15:0] l;
    int          c;
    c = cyc;
    if (rs[ch] < c && c < re[ch]) begin
      if (sten[ch]) begin
        while (tq[ch].size() > 0 && tq[ch][tq[ch].size()-1].cyc > c) void'(tq[ch].pop_back());
        if (dq[ch].size() > 0) void'(dq[ch].pop_back());
        e.cyc = c + 1;
        e.num = mmap(mlfsr, mx[ch]);
        dq[ch].push_back(e);
        re[ch] = c + 1;
      end
    end else if (c != re[ch]) begin
      rs[ch] = c;
      re[ch] = c + 1 + RT * TD;
      l = mlfsr;
      for (int k = 1; k <= RT; k++) begin
        repeat (TD) l = mstep(l);
        e.cyc = c + 1 + k * TD;
        e.num = mmap(l, mx[ch]);
        if (k < RT) tq[ch].push_back(e);
        else        dq[ch].push_back(e);
      end
    end
  endtask

  task automatic step(bit p);
    @(negedge clk);
    #1;
    if (p) begin
      press_model(0);
      press_model(1);
    end
    run = p;
  endtask

  task automatic mid_reset();
    @(negedge clk);
    #1;
    rst = 1'b1;
    run = 1'b0;
    for (int ch = 0; ch < 2; ch++) begin
      dq[ch].delete();
      tq[ch].delete();
      rs[ch] = -1;
      re[ch] = -1;
    end
    #1;
    for (int ch = 0; ch < 2; ch++) begin
      chk($sformatf("rst_num%0d", ch), num_w[ch], 0);
      chk($sformatf("rst_rolling%0d", ch), rol_w[ch], 0);
      chk($sformatf("rst_done%0d", ch), done_w[ch], 0);
    end
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    for (int ch = 0; ch < 2; ch++) begin
      chk($sformatf("reset_num%0d", ch), num_w[ch], 0);
      chk($sformatf("reset_rolling%0d", ch), rol_w[ch], 0);
      chk($sformatf("reset_done%0d", ch), done_w[ch], 0);
    end
    chk("lfsr_seed", lq, 16'hACE1);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("lfsr_step1", lq, 16'hE270);
    @(negedge clk);
    chk("lfsr_step2", lq, 16'h7138);

    chk("map_9_9", digit_map(4'h9, 4'd9), 9);
    chk("map_C_9", digit_map(4'hC, 4'd9), 2);
    chk("map_F_9", digit_map(4'hF, 4'd9), 5);
    chk("map_F_5", digit_map(4'hF, 4'd5), 3);

    // Full roll, then early stop at t+6.
    step(1'b1); repeat (16) step(1'b0);
    step(1'b1); repeat (5) step(1'b0); step(1'b1); repeat (10) step(1'b0);
    // Press on the final tick, then a press at done+1.
    step(1'b1); repeat (11) step(1'b0); step(1'b1); step(1'b0); step(1'b1);
    repeat (16) step(1'b0);
    // Press in the done cycle is lost.
    step(1'b1); repeat (12) step(1'b0); step(1'b1); repeat (4) step(1'b0);
    // Reset in the middle of a roll.
    step(1'b1); repeat (6) step(1'b0);
    mid_reset();
    repeat (3) step(1'b0);
    // Random press stream.
    repeat (1500) step($urandom_range(0, 9) == 0);
    repeat (20) step(1'b0);

    for (int ch = 0; ch < 2; ch++) begin
      chk($sformatf("done_q_empty%0d", ch), dq[ch].size(), 0);
      chk($sformatf("tick_q_empty%0d", ch), tq[ch].size(), 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
